sprite_palette_bank: RTL and testbench
======================================

# sprite_palette_bank

Multi-bank, runtime-writable colour lookup for sprite rendering. It replaces fixed per-sprite palette ROMs with one shared RAM of `BANKS` palettes of `2**IDX_W` entries each. It sits between the sprite ROM index output and the VGA colour mux. It adds:
- a reset-time initialisation sequence;
- a 2-stage pipelined lookup;
- a transparency flag;
- a frame-counted hit-flash effect.

## Interface
Parameters:
- `IDX_W`, 4, colour index width; each bank holds `2**IDX_W` entries.
- `BANKS`, 4, number of palettes (≥1); `BANK_W = $clog2(BANKS)`, min 1.
- `CH_W`, 4, bits per colour channel.
- `TRANSP_IDX`, 0, index value treated as transparent in every bank.
- `FLASH_FRAMES`, 8, frame ticks a flash lasts (1..255).

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `rd_valid`  in  1  lookup request this cycle.
- `rd_bank`  in  BANK_W  palette select.
- `rd_index`  in  IDX_W  colour index.
- `wr_en`  in  1  palette write strobe.
- `wr_bank`  in  BANK_W  write bank.
- `wr_index`  in  IDX_W  write entry.
- `wr_rgb`  in  3*CH_W  `{r,g,b}` to store.
- `frame_tick`  in  1  one-cycle pulse per frame (vsync edge).
- `flash_start`  in  1  pulse: begin or restart the flash.
- `red`, `green`, `blue`  out  CH_W each  looked-up colour.
- `out_valid`  out  1  colour outputs valid this cycle.
- `transparent`  out  1  pixel is the transparent index.
- `busy`  out  1  initialisation in progress.
- `flashing`  out  1  flash effect active.

## Operation
Controller FSM: INIT → RUN.
- Reset enters INIT with counter `init_addr = 0`.
- INIT writes one entry per cycle: `ram[init_addr] = DEFAULT_PAL[init_addr mod 16]`. The address is `{bank, index}` flattened, bank in the high bits.
- After address `BANKS*2**IDX_W - 1` is written, the FSM moves to RUN.

During INIT:
- `busy` = 1.
- `wr_en` is ignored.
- `rd_valid` is dropped; no `out_valid` results.

In RUN:
- `wr_en` writes `wr_rgb` to `{wr_bank, wr_index}`.
- A read is accepted every cycle; the pipeline has no stalls.
- A `bank` value ≥ `BANKS` (non-power-of-2 `BANKS`) is ignored for writes. For reads it returns `{0,0,0}`, still with `out_valid`.

Transparency:
- `transparent` = (`rd_index == TRANSP_IDX`), delayed to align with `out_valid`.
- Outputs still show the stored colour.

Flash counter (8-bit, `flash_cnt`):
- `flash_start` loads `FLASH_FRAMES`.
- Otherwise, `frame_tick` with `flash_cnt != 0` decrements it.
- `flashing` = (`flash_cnt != 0`).
- If `flash_start` and `frame_tick` arrive in the same cycle, start wins: the counter loads `FLASH_FRAMES` with no decrement.
- During INIT, flash inputs are still honoured.

Output colour:
- If `flashing` is sampled at stage 2 and the pixel is not transparent, outputs are all ones (`{CH_W{1'b1}}` per channel).
- Otherwise outputs are the stored colour.

## Timing
- Reset values: `out_valid` 0, `red/green/blue` 0, `transparent` 0, `busy` 1, `flashing` 0, `flash_cnt` 0, pipeline valids 0.
- INIT length is `BANKS*2**IDX_W` cycles (64 at defaults).
  - `busy` is 1 from the cycle `Reset` is sampled high through the last INIT write.
  - `busy` is 0 on the first RUN cycle.
  - `Reset` asserted at any point restarts INIT from address 0 and clears the pipeline and flash.
- Read latency is 2 cycles:
  - Stage 1 registers the address, index compare and valid.
  - Stage 2 registers the RAM data, forced colour and `out_valid`.
  - A request at cycle N gives outputs at N+2.
- Read/write collision on the same entry in the same cycle returns the old value. A read issued at N+1 returns the new value.
- A `flashing` change takes effect on outputs 1 cycle after `flash_cnt` updates, via the stage-2 sample.
- Outputs hold their last value while `out_valid` = 0.

## Structure
- Package `palette_pkg`:
  - `typedef logic [11:0] rgb12_t`.
  - `DEFAULT_PAL` as `localparam rgb12_t [0:15]`. Entries used by the test plan: 0 = `0xD1C`, 2 = `0xF0F`, 4 = `0xFCA`, 15 = `0x116`.
  - FSM state enum `{INIT, RUN}`.
- One sub-module, `palette_ram`: 1 write / 1 read synchronous RAM, depth `BANKS*2**IDX_W`, width `3*CH_W`, read-old-on-collision.
- The top level holds the FSM, init counter, flash counter and output pipeline.

## Test plan
- Reset for 1 cycle, then idle → `busy` = 1 for exactly 64 cycles. Reads then return bank 3 index 4 = `{F,C,A}` and bank 0 index 15 = `{1,1,6}`.
- Write bank 1 index 2 = `0x3A5`; read bank 1 index 2 in the same cycle → old `{F,0,F}`. Read again the next cycle → `{3,A,5}` at request + 2.
- Back-to-back reads of indices 0..15 in bank 2 → 16 consecutive `out_valid` cycles, each at 2-cycle latency. `transparent` = 1 only for index 0.
- `flash_start`, then 8 `frame_tick`s with reads of index 4 (opaque) and index 0 (transparent):
  - While flashing, index 4 outputs `{F,F,F}` and index 0 outputs `{D,1,C}` with `transparent` = 1.
  - `flashing` drops after the 8th tick.
- `flash_start` and `frame_tick` in the same cycle while `flash_cnt` = 3 → `flash_cnt` = 8.
- Assert `Reset` at init address 30, then write during INIT → write ignored. INIT restarts at 0 and `busy` lasts 64 more cycles.

Source files
------------

// File: rtl/sprite_palette_bank_pkg.sv
// palette_pkg: shared types and constants for the sprite palette bank.
//   rgb12_t     - 12-bit {r,g,b} colour word (4 bits per channel)
//   state_t     - controller state (INIT fills the RAM, RUN serves lookups)
//   DEFAULT_PAL - 16-entry palette replicated into every bank at init
//   FLASH_W     - width of the hit-flash frame counter
package palette_pkg;

    typedef logic [11:0] rgb12_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FLASH_W = 8;

    localparam rgb12_t [0:15] DEFAULT_PAL = '{
        12'hD1C, 12'h000, 12'hF0F, 12'h0F0,
        12'hFCA, 12'h00F, 12'hF00, 12'hFF0,
        12'h0FF, 12'h888, 12'h444, 12'hCCC,
        12'h963, 12'h369, 12'h5A5, 12'h116
    };

endpackage

// File: rtl/sprite_palette_bank_if.sv
// sprite_palette_bank_if: lookup, palette-write, flash and colour-output
// signals of the sprite palette bank.
//   master - sprite/frame logic side: drives requests, receives colour
//   slave  - palette bank side
interface sprite_palette_bank_if #(
    parameter int IDX_W  = 4,
    parameter int BANK_W = 2,
    parameter int CH_W   = 4
);
    logic              rd_valid;
    logic [BANK_W-1:0] rd_bank;
    logic [IDX_W-1:0]  rd_index;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_index;
    logic [3*CH_W-1:0] wr_rgb;
    logic              frame_tick;
    logic              flash_start;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              out_valid;
    logic              transparent;
    logic              busy;
    logic              flashing;

    modport master (
        output rd_valid, rd_bank, rd_index, wr_en, wr_bank, wr_index, wr_rgb,
               frame_tick, flash_start,
        input  red, green, blue, out_valid, transparent, busy, flashing
    );

    modport slave (
        input  rd_valid, rd_bank, rd_index, wr_en, wr_bank, wr_index, wr_rgb,
               frame_tick, flash_start,
        output red, green, blue, out_valid, transparent, busy, flashing
    );
endinterface

// File: rtl/sprite_palette_bank_ram.sv
// palette_ram: 1-write / 1-read synchronous RAM holding all palette banks.
//   clk   - clock
//   we    - write enable; waddr/wdata - write port
//   raddr - read address; rdata - registered read data (one cycle later)
// A read and write to the same address in one cycle returns the old word.
module palette_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: shared runtime-writable palette RAM for sprites.
//   Clk, Reset - clock, synchronous active-high reset
//   bus        - slave side: lookup request (rd_*), palette write (wr_*),
//                frame_tick / flash_start, colour out with out_valid,
//                transparent, busy (init running), flashing
// After reset every bank is filled from DEFAULT_PAL, one entry per cycle.
// Lookups take two cycles; a pending hit-flash forces opaque pixels white.
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int BANKS        = 4,
    parameter int CH_W         = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic Clk,
    input  logic Reset,
    sprite_palette_bank_if.slave bus
);
    localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int ADDR_W    = BANK_W + IDX_W;
    localparam int DEPTH     = BANKS * (2 ** IDX_W);
    localparam int RGB_W     = 3 * CH_W;
    localparam int PAL_SEL_W = (ADDR_W < 4) ? ADDR_W : 4;

    // Rescale a 4-bit palette channel to CH_W bits (keeps the MSBs).
    function automatic logic [CH_W-1:0] scale4(input logic [3:0] n);
        logic [CH_W+3:0] t;
        t = {n, CH_W'(0)};
        return t[CH_W+3:4];
    endfunction

    function automatic logic [RGB_W-1:0] pal_word(input logic [3:0] sel);
        rgb12_t p;
        p = DEFAULT_PAL[sel];
        return {scale4(p[11:8]), scale4(p[7:4]), scale4(p[3:0])};
    endfunction

    // Out-of-range bank reads black; otherwise flash whitens opaque pixels.
    function automatic logic [RGB_W-1:0] shade(input logic [RGB_W-1:0] stored,
                                               input logic bad, input logic transp,
                                               input logic flash);
        if (bad)
            return '0;
        if (flash && !transp)
            return '1;
        return stored;
    endfunction

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  init_addr;
    logic [FLASH_W-1:0] flash_cnt;
    logic               rd_ok, wr_ok, rd_accept;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
    logic [RGB_W-1:0]   ram_wdata, ram_rdata;
    logic               vld_p1, transp_p1, bad_p1;
    logic               vld_p2, transp_p2;
    logic [RGB_W-1:0]   rgb_p2;

    assign rd_ok     = int'(bus.rd_bank) < BANKS;
    assign wr_ok     = int'(bus.wr_bank) < BANKS;
    assign ram_raddr = rd_ok ? {bus.rd_bank, bus.rd_index} : '0;

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (init_addr == ADDR_W'(DEPTH - 1)) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    // INIT owns the write port; user writes and reads wait for RUN.
    always_comb begin
        bus.busy  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = {bus.wr_bank, bus.wr_index};
        ram_wdata = bus.wr_rgb;
        rd_accept = 1'b0;
        case (state)
            INIT: begin
                bus.busy  = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = init_addr;
                ram_wdata = pal_word(4'(init_addr[PAL_SEL_W-1:0]));
            end
            RUN: begin
                ram_we    = bus.wr_en && wr_ok;
                rd_accept = bus.rd_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || state != INIT)
            init_addr <= '0;
        else
            init_addr <= init_addr + 1'b1;
    end

    // Start has priority over a coincident tick.
    always_ff @(posedge Clk) begin
        if (Reset)
            flash_cnt <= '0;
        else if (bus.flash_start)
            flash_cnt <= FLASH_W'(FLASH_FRAMES);
        else if (bus.frame_tick && flash_cnt != '0)
            flash_cnt <= flash_cnt - 1'b1;
    end

    assign bus.flashing = (flash_cnt != '0);

    palette_ram #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(RGB_W)) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Stage 1: address captured by the RAM read register, plus valid,
    // transparency compare and bank-range flag.
    always_ff @(posedge Clk) begin
        if (Reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_accept;
    end

    always_ff @(posedge Clk) begin
        transp_p1 <= (bus.rd_index == IDX_W'(TRANSP_IDX));
        bad_p1    <= !rd_ok;
    end

    // Stage 2: final colour with flash applied; outputs hold between hits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p2    <= 1'b0;
            transp_p2 <= 1'b0;
            rgb_p2    <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                transp_p2 <= transp_p1;
                rgb_p2    <= shade(ram_rdata, bad_p1, transp_p1, bus.flashing);
            end
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.transparent = transp_p2;
    assign bus.red         = rgb_p2[3*CH_W-1:2*CH_W];
    assign bus.green       = rgb_p2[2*CH_W-1:CH_W];
    assign bus.blue        = rgb_p2[CH_W-1:0];
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: directed scenarios plus a
// randomized phase, all outputs compared every cycle against a palette /
// flash-counter reference model kept here.
module tb_sprite_palette_bank;
    import palette_pkg::*;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    sprite_palette_bank_if #(.IDX_W(4), .BANK_W(2), .CH_W(4)) bus ();

    sprite_palette_bank #(
        .IDX_W(4), .BANKS(4), .CH_W(4), .TRANSP_IDX(0), .FLASH_FRAMES(8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    logic [11:0] mram [0:63];
    int          init_left;
    int          fcnt;
    logic        p_vld, p_tr;
    logic [11:0] p_rgb;
    logic        e_vld, e_tr;
    logic [11:0] e_rgb;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (Reset) begin
            for (int i = 0; i < 64; i++) mram[i] = DEFAULT_PAL[i % 16];
            init_left = 64;
            fcnt      = 0;
            p_vld     = 1'b0;
            e_vld     = 1'b0;
            e_tr      = 1'b0;
            e_rgb     = 12'h000;
        end else begin
            // pixel finishing now sees the flash state held during this cycle
            e_vld = p_vld;
            if (p_vld) begin
                e_tr  = p_tr;
                e_rgb = (fcnt != 0 && !p_tr) ? 12'hFFF : p_rgb;
            end
            p_vld = (init_left == 0) && bus.rd_valid;
            if (p_vld) begin
                p_tr  = (bus.rd_index == 4'd0);
                p_rgb = mram[int'(bus.rd_bank) * 16 + int'(bus.rd_index)];
            end
            if (init_left == 0 && bus.wr_en)
                mram[int'(bus.wr_bank) * 16 + int'(bus.wr_index)] = bus.wr_rgb;
            if (bus.flash_start)
                fcnt = 8;
            else if (bus.frame_tick && fcnt > 0)
                fcnt = fcnt - 1;
            if (init_left > 0)
                init_left = init_left - 1;
        end
    endtask

    task automatic check_outputs();
        check_val("busy", 32'(bus.busy), 32'(init_left > 0));
        check_val("flashing", 32'(bus.flashing), 32'(fcnt != 0));
        check_val("out_valid", 32'(bus.out_valid), 32'(e_vld));
        check_val("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e_rgb));
        check_val("transparent", 32'(bus.transparent), 32'(e_tr));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.rd_valid    = 1'b0;
        bus.rd_bank     = '0;
        bus.rd_index    = '0;
        bus.wr_en       = 1'b0;
        bus.wr_bank     = '0;
        bus.wr_index    = '0;
        bus.wr_rgb      = '0;
        bus.frame_tick  = 1'b0;
        bus.flash_start = 1'b0;
    endtask

    task automatic read_req(input int bank, input int idx);
        bus.rd_valid = 1'b1;
        bus.rd_bank  = 2'(bank);
        bus.rd_index = 4'(idx);
    endtask

    // Counts cycles with busy high, starting from the current cycle.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            step();
            idle_inputs();
        end
    endtask

    function automatic logic [31:0] rgb_now();
        return 32'({bus.red, bus.green, bus.blue});
    endfunction

    initial begin
        int n, ov;
        Reset = 1'b1;
        idle_inputs();
        step();
        check_val("reset_valid", 32'(bus.out_valid), 32'd0);
        check_val("reset_busy", 32'(bus.busy), 32'd1);
        check_val("reset_rgb", rgb_now(), 32'h000);
        Reset = 1'b0;

        count_busy(n);
        check_val("init_len", 32'(n), 32'd64);

        read_req(3, 4); step(); idle_inputs(); step();
        check_val("b3i4", rgb_now(), 32'hFCA);
        check_val("b3i4_vld", 32'(bus.out_valid), 32'd1);
        read_req(0, 15); step(); idle_inputs(); step();
        check_val("b0i15", rgb_now(), 32'h116);

        // write/read collision, then read-after-write
        read_req(1, 2);
        bus.wr_en = 1'b1; bus.wr_bank = 2'd1; bus.wr_index = 4'd2; bus.wr_rgb = 12'h3A5;
        step();
        idle_inputs(); read_req(1, 2); step();
        check_val("collide_old", rgb_now(), 32'hF0F);
        idle_inputs(); step();
        check_val("after_write", rgb_now(), 32'h3A5);

        // back-to-back sweep of bank 2
        ov = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) read_req(2, i); else idle_inputs();
            step();
            if (bus.out_valid) ov++;
            if (i >= 1 && i <= 16)
                check_val("sweep_transp", 32'(bus.transparent), 32'(i == 1));
        end
        idle_inputs(); step();
        if (bus.out_valid) ov++;
        check_val("sweep_count", 32'(ov), 32'd16);

        // flash: opaque index whitened, transparent index keeps colour
        bus.flash_start = 1'b1; step(); idle_inputs();
        for (int k = 1; k <= 8; k++) begin
            read_req(0, 4); step();
            idle_inputs(); read_req(0, 0); step();
            check_val("flash_opaque", rgb_now(), 32'hFFF);
            idle_inputs(); bus.frame_tick = 1'b1; step(); idle_inputs();
            check_val("flash_transp_rgb", rgb_now(), 32'hD1C);
            check_val("flash_transp", 32'(bus.transparent), 32'd1);
            check_val("flashing_k", 32'(bus.flashing), 32'(k < 8));
        end

        // start and tick together at count 3: reload without decrement
        bus.flash_start = 1'b1; step(); idle_inputs();
        for (int k = 0; k < 5; k++) begin
            bus.frame_tick = 1'b1; step(); idle_inputs();
        end
        bus.flash_start = 1'b1; bus.frame_tick = 1'b1; step(); idle_inputs();
        n = 0;
        while (bus.flashing && n < 20) begin
            n++;
            bus.frame_tick = 1'b1; step(); idle_inputs();
        end
        check_val("coincident_ticks", 32'(n), 32'd8);

        // reset mid-init, write during init is dropped
        Reset = 1'b1; step(); Reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        Reset = 1'b1; step(); Reset = 1'b0;
        bus.wr_en = 1'b1; bus.wr_bank = 2'd1; bus.wr_index = 4'd2; bus.wr_rgb = 12'h123;
        count_busy(n);
        check_val("reinit_len", 32'(n), 32'd64);
        read_req(1, 2); step(); idle_inputs(); step();
        check_val("init_write_ignored", rgb_now(), 32'hF0F);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            Reset           = ($urandom_range(0, 399) == 0);
            bus.rd_valid    = $urandom_range(0, 3) != 0;
            bus.rd_bank     = 2'($urandom_range(0, 3));
            bus.rd_index    = 4'($urandom_range(0, 15));
            bus.wr_en       = ($urandom_range(0, 3) == 0);
            bus.wr_bank     = 2'($urandom_range(0, 3));
            bus.wr_index    = 4'($urandom_range(0, 15));
            bus.wr_rgb      = 12'($urandom);
            bus.frame_tick  = ($urandom_range(0, 7) == 0);
            bus.flash_start = ($urandom_range(0, 39) == 0);
            step();
        end
        Reset = 1'b0;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
